// File: rtl/raw_data_lane_seq_pkg.sv
// Shared types for the raw-data lane sequencer: one-hot FSM state encoding.
package raw_data_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT   = 3'b001,
    ST_IDLE   = 3'b010,
    ST_ENCODE = 3'b100
  } state_e;

endpackage

// File: rtl/raw_data_lane_seq_next_sel.sv
// Combinational lane scanner: lowest set strobe bit, and next set bit strictly above the current lane.
module raw_lane_next_sel #(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]         strb_i,
  input  logic [$clog2(NUM_LANES)-1:0] cur_i,
  output logic [$clog2(NUM_LANES)-1:0] next_o,
  output logic                         has_next_o,
  output logic [$clog2(NUM_LANES)-1:0] first_o
);

  localparam int unsigned SEL_W = $clog2(NUM_LANES);

  // Descending scan so the last hit is the lowest qualifying lane.
  always_comb begin
    next_o     = '0;
    has_next_o = 1'b0;
    first_o    = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (strb_i[SEL_W'(i)]) begin
        first_o = SEL_W'(i);
        if (i > int'(cur_i)) begin
          next_o     = SEL_W'(i);
          has_next_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/raw_data_lane_seq.sv
// Raw-data lane sequencer: pops one ingress word, then pushes its lanes one per cycle to the egress FIFO.
// Optional RAW_DATA_STRB_SKIP_EN: skip zero-strobe lanes and drop all-zero words; otherwise every lane is pushed.
module raw_data_lane_seq #(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         raw_data_in_fifo_empty_i,
  input  logic [NUM_LANES-1:0]         raw_data_in_wstrb_i,
  output logic                         raw_data_in_fifo_pop_o,
  output logic                         raw_data_in_index_pop_o,
  output logic                         raw_data_in_wstrb_pop_o,
  input  logic                         raw_data_out_fifo_full_i,
  output logic                         raw_data_out_fifo_push_o,
  output logic                         raw_data_out_fifo_clr_o,
  output logic                         raw_data_out_index_clr_o,
  output logic [$clog2(NUM_LANES)-1:0] raw_data_sel_o,
  output logic                         word_done_o,
  output logic                         busy_o
);

  import raw_data_pkg::*;

  localparam int unsigned SEL_W = $clog2(NUM_LANES);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     index_q, index_d;
  logic [NUM_LANES-1:0] strb_q, strb_d;
  logic [NUM_LANES-1:0] eff_strb;
  logic [NUM_LANES-1:0] scan_strb;
  logic [SEL_W-1:0]     next_sel;
  logic [SEL_W-1:0]     first_sel;
  logic                 has_next;
  logic                 pop;

`ifdef RAW_DATA_STRB_SKIP_EN
  assign eff_strb = raw_data_in_wstrb_i;
`else
  logic unused_wstrb;
  assign eff_strb     = {NUM_LANES{1'b1}};
  assign unused_wstrb = ^raw_data_in_wstrb_i;
`endif

  // In IDLE the scanner looks at the incoming head word; in ENCODE at the latched strobes.
  assign scan_strb = (state_q == ST_IDLE) ? eff_strb : strb_q;

  raw_lane_next_sel #(
    .NUM_LANES (NUM_LANES)
  ) u_next_sel (
    .strb_i     (scan_strb),
    .cur_i      (index_q),
    .next_o     (next_sel),
    .has_next_o (has_next),
    .first_o    (first_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      index_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d                  = state_q;
    index_d                  = index_q;
    strb_d                   = strb_q;
    pop                      = 1'b0;
    raw_data_out_fifo_push_o = 1'b0;
    raw_data_out_fifo_clr_o  = 1'b0;
    raw_data_out_index_clr_o = 1'b0;
    word_done_o              = 1'b0;
    busy_o                   = 1'b1;
    raw_data_sel_o           = index_q;

    case (state_q)
      ST_INIT: begin
        raw_data_out_fifo_clr_o  = 1'b1;
        raw_data_out_index_clr_o = 1'b1;
        index_d                  = '0;
        state_d                  = ST_IDLE;
      end
      ST_IDLE: begin
        busy_o = 1'b0;
        if (!raw_data_in_fifo_empty_i) begin
          pop    = 1'b1;
          strb_d = eff_strb;
          if (eff_strb == '0) begin
            word_done_o = 1'b1;
          end else begin
            index_d = first_sel;
            state_d = ST_ENCODE;
          end
        end
      end
      ST_ENCODE: begin
        if (!raw_data_out_fifo_full_i) begin
          raw_data_out_fifo_push_o = 1'b1;
          if (has_next) begin
            index_d = next_sel;
          end else begin
            word_done_o = 1'b1;
            index_d     = '0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        index_d = '0;
        state_d = ST_INIT;
      end
    endcase
  end

  assign raw_data_in_fifo_pop_o  = pop;
  assign raw_data_in_index_pop_o = pop;
  assign raw_data_in_wstrb_pop_o = pop;

endmodule

// File: tb/tb_raw_data_lane_seq.sv
// Directed self-checking bench for raw_data_lane_seq (4-lane and 8-lane instances).
module tb_raw_data_lane_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       empty4, full4;
  logic [3:0] wstrb4;
  logic       pop4, ipop4, wpop4, push4, fclr4, iclr4, done4, busy4;
  logic [1:0] sel4;
  logic       empty8, full8;
  logic [7:0] wstrb8;
  logic       pop8, ipop8, wpop8, push8, fclr8, iclr8, done8, busy8;
  logic [2:0] sel8;

  int n_err = 0;
  int n_chk = 0;

  raw_data_lane_seq #(.NUM_LANES(4)) u_dut4 (
    .clk                      (clk),
    .reset                    (reset),
    .raw_data_in_fifo_empty_i (empty4),
    .raw_data_in_wstrb_i      (wstrb4),
    .raw_data_in_fifo_pop_o   (pop4),
    .raw_data_in_index_pop_o  (ipop4),
    .raw_data_in_wstrb_pop_o  (wpop4),
    .raw_data_out_fifo_full_i (full4),
    .raw_data_out_fifo_push_o (push4),
    .raw_data_out_fifo_clr_o  (fclr4),
    .raw_data_out_index_clr_o (iclr4),
    .raw_data_sel_o           (sel4),
    .word_done_o              (done4),
    .busy_o                   (busy4)
  );

  raw_data_lane_seq #(.NUM_LANES(8)) u_dut8 (
    .clk                      (clk),
    .reset                    (reset),
    .raw_data_in_fifo_empty_i (empty8),
    .raw_data_in_wstrb_i      (wstrb8),
    .raw_data_in_fifo_pop_o   (pop8),
    .raw_data_in_index_pop_o  (ipop8),
    .raw_data_in_wstrb_pop_o  (wpop8),
    .raw_data_out_fifo_full_i (full8),
    .raw_data_out_fifo_push_o (push8),
    .raw_data_out_fifo_clr_o  (fclr8),
    .raw_data_out_index_clr_o (iclr8),
    .raw_data_sel_o           (sel8),
    .word_done_o              (done8),
    .busy_o                   (busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic exp4(input string tag, input int pop, input int push, input int sel,
                      input int done, input int busy, input int clr);
    check({tag, ".pop"},   32'(pop4),  pop);
    check({tag, ".ipop"},  32'(ipop4), pop);
    check({tag, ".wpop"},  32'(wpop4), pop);
    check({tag, ".push"},  32'(push4), push);
    check({tag, ".sel"},   32'(sel4),  sel);
    check({tag, ".done"},  32'(done4), done);
    check({tag, ".busy"},  32'(busy4), busy);
    check({tag, ".fclr"},  32'(fclr4), clr);
    check({tag, ".iclr"},  32'(iclr4), clr);
  endtask

  task automatic exp8(input string tag, input int pop, input int push, input int sel,
                      input int done, input int busy, input int clr);
    check({tag, ".pop"},   32'(pop8),  pop);
    check({tag, ".ipop"},  32'(ipop8), pop);
    check({tag, ".wpop"},  32'(wpop8), pop);
    check({tag, ".push"},  32'(push8), push);
    check({tag, ".sel"},   32'(sel8),  sel);
    check({tag, ".done"},  32'(done8), done);
    check({tag, ".busy"},  32'(busy8), busy);
    check({tag, ".fclr"},  32'(fclr8), clr);
    check({tag, ".iclr"},  32'(iclr8), clr);
  endtask

  // Inputs change right after a falling edge; outputs are checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One word on the 4-lane instance; sels holds the expected lane order, one nibble per push.
  task automatic run_word4(input string tag, input logic [3:0] strb, input logic [31:0] sels, input int n);
    empty4 = 1'b0;
    wstrb4 = strb;
    #1 exp4({tag, "_pop"}, 1, 0, 0, (n == 0) ? 1 : 0, 0, 0);
    tick();
    empty4 = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1 exp4($sformatf("%s_l%0d", tag, k), 0, 1, int'(sels[4*k +: 4]), (k == n - 1) ? 1 : 0, 1, 0);
      tick();
    end
    #1 exp4({tag, "_idle"}, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    empty4 = 1'b1;
    full4  = 1'b0;
    wstrb4 = 4'h0;
    empty8 = 1'b1;
    full8  = 1'b0;
    wstrb8 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset release: one INIT cycle with clears, then quiet IDLE.
    #1 exp4("t1_init", 0, 0, 0, 0, 1, 1);
    exp8("t1_init8", 0, 0, 0, 0, 1, 1);
    tick();
    #1 exp4("t1_idle", 0, 0, 0, 0, 0, 0);
    exp8("t1_idle8", 0, 0, 0, 0, 0, 0);
    tick();
    #1 exp4("t1_idle2", 0, 0, 0, 0, 0, 0);

    // Full-strobe word: lanes 0..3, five cycles.
    run_word4("t2", 4'hF, 32'h3210, 4);

    // Partial and zero strobes.
`ifdef RAW_DATA_STRB_SKIP_EN
    run_word4("t3a", 4'b1010, 32'h31, 2);
    run_word4("t3b", 4'b0000, 32'h0, 0);
    run_word4("t3c", 4'b0100, 32'h2, 1);
`else
    run_word4("t3a", 4'b1010, 32'h3210, 4);
    run_word4("t3b", 4'b0000, 32'h3210, 4);
    run_word4("t3c", 4'b0100, 32'h3210, 4);
`endif

    // Pop concurrent with full, then a 3-cycle stall on lane 2.
    empty4 = 1'b0;
    wstrb4 = 4'hF;
    full4  = 1'b1;
    #1 exp4("t4_pop", 1, 0, 0, 0, 0, 0);
    tick();
    empty4 = 1'b1;
    #1 exp4("t4_stall0", 0, 0, 0, 0, 1, 0);
    full4 = 1'b0;
    #1 exp4("t4_l0", 0, 1, 0, 0, 1, 0);
    tick();
    #1 exp4("t4_l1", 0, 1, 1, 0, 1, 0);
    tick();
    full4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 exp4($sformatf("t4_hold%0d", c), 0, 0, 2, 0, 1, 0);
      tick();
    end
    full4 = 1'b0;
    #1 exp4("t4_l2", 0, 1, 2, 0, 1, 0);
    tick();
    #1 exp4("t4_l3", 0, 1, 3, 1, 1, 0);
    tick();
    #1 exp4("t4_idle", 0, 0, 0, 0, 0, 0);

    // Reset mid-word at lane 1.
    empty4 = 1'b0;
    wstrb4 = 4'hF;
    #1 exp4("t5_pop", 1, 0, 0, 0, 0, 0);
    tick();
    empty4 = 1'b1;
    #1 exp4("t5_l0", 0, 1, 0, 0, 1, 0);
    tick();
    #1 exp4("t5_l1", 0, 1, 1, 0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 exp4("t5_init", 0, 0, 0, 0, 1, 1);
    tick();
    #1 exp4("t5_idle", 0, 0, 0, 0, 0, 0);
    tick();
    #1 exp4("t5_idle2", 0, 0, 0, 0, 0, 0);
    run_word4("t5_new", 4'hF, 32'h3210, 4);

    // 8 lanes, all pushed, two back-to-back words: pop every 9th cycle.
`ifdef RAW_DATA_STRB_SKIP_EN
    wstrb8 = 8'hFF;
`else
    wstrb8 = 8'h00;
`endif
    empty8 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      #1 exp8($sformatf("t6_w%0d_pop", w), 1, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 8; k++) begin
        #1 exp8($sformatf("t6_w%0d_l%0d", w, k), 0, 1, k, (k == 7) ? 1 : 0, 1, 0);
        tick();
      end
    end
    empty8 = 1'b1;
    #1 exp8("t6_idle", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
